// File: rtl/exec_core_pkg.sv
// Shared constants and operation encodings for the exec_core datapath.
package exec_core_pkg;

   localparam int WIDTH = 16;
   localparam int NREGS = 8;
   localparam int IDXW  = $clog2(NREGS);

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      NOT = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      SHL  = 2'b01,
      SHR  = 2'b10,
      ASR  = 2'b11
   } shift_op_e;

endpackage

// File: rtl/exec_core_regfile.sv
// 8x16 register file: one synchronous write port with async active-low reset,
// one combinational read port.
module exec_core_regfile
   import exec_core_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_write,
   input  logic [IDXW-1:0]  i_writeNum,
   input  logic [WIDTH-1:0] i_dataIn,
   input  logic [IDXW-1:0]  i_readNum,
   output logic [WIDTH-1:0] o_rdData
);

   logic [NREGS-1:0][WIDTH-1:0] r_regs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs <= '0;
      end else if (i_write) begin
         r_regs[i_writeNum] <= i_dataIn;
      end
   end

   assign o_rdData = r_regs[i_readNum];

endmodule

// File: rtl/exec_core.sv
// Execution core: register file, A/B operands, B shifter, 4-op ALU, C and Z/N/V.
// Optional macro EXEC_CORE_WRITE_FORWARD_EN forwards data_in to a same-cycle read.
module exec_core
   import exec_core_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic [IDXW-1:0]  writenum,
   input  logic             write,
   input  logic [IDXW-1:0]  readnum,
   input  logic             loada,
   input  logic             loadb,
   input  logic [1:0]       shift,
   input  logic             asel,
   input  logic             bsel,
   input  logic [WIDTH-1:0] sximm5,
   input  logic [1:0]       aluop,
   input  logic             loadc,
   input  logic             loads,
   output logic [WIDTH-1:0] datapath_out,
   output logic             z_out,
   output logic             n_out,
   output logic             v_out
);

   logic [WIDTH-1:0] w_rfRaw;
   logic [WIDTH-1:0] w_rfRd;
   logic [WIDTH-1:0] w_shOut;
   logic [WIDTH-1:0] w_ain;
   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_result;
   logic             w_z;
   logic             w_n;
   logic             w_v;
   shift_op_e        w_shiftOp;
   alu_op_e          w_aluOp;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_c;
   logic             r_z;
   logic             r_n;
   logic             r_v;

   exec_core_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_write    (write),
      .i_writeNum (writenum),
      .i_dataIn   (data_in),
      .i_readNum  (readnum),
      .o_rdData   (w_rfRaw)
   );

`ifdef EXEC_CORE_WRITE_FORWARD_EN
   // Bypass so a same-cycle write is seen by the operand capture
   assign w_rfRd = (write && (writenum == readnum)) ? data_in : w_rfRaw;
`else
   assign w_rfRd = w_rfRaw;
`endif

   assign w_shiftOp = shift_op_e'(shift);
   assign w_aluOp   = alu_op_e'(aluop);

   always_comb begin
      w_shOut = r_b;
      case (w_shiftOp)
         NONE:    w_shOut = r_b;
         SHL:     w_shOut = {r_b[WIDTH-2:0], 1'b0};
         SHR:     w_shOut = {1'b0, r_b[WIDTH-1:1]};
         ASR:     w_shOut = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
         default: w_shOut = r_b;
      endcase
   end

   assign w_ain = asel ? '0 : r_a;
   assign w_bin = bsel ? sximm5 : w_shOut;

   // Overflow is only meaningful for the arithmetic ops; logic ops clear it
   always_comb begin
      w_result = '0;
      w_v      = 1'b0;
      case (w_aluOp)
         ADD: begin
            w_result = w_ain + w_bin;
            w_v      = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) &&
                       (w_result[WIDTH-1] != w_ain[WIDTH-1]);
         end
         SUB: begin
            w_result = w_ain - w_bin;
            w_v      = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) &&
                       (w_result[WIDTH-1] != w_ain[WIDTH-1]);
         end
         AND: begin
            w_result = w_ain & w_bin;
            w_v      = 1'b0;
         end
         NOT: begin
            w_result = ~w_bin;
            w_v      = 1'b0;
         end
         default: begin
            w_result = '0;
            w_v      = 1'b0;
         end
      endcase
   end

   assign w_z = (w_result == '0);
   assign w_n = w_result[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= '0;
         r_z <= 1'b0;
         r_n <= 1'b0;
         r_v <= 1'b0;
      end else begin
         if (loada) r_a <= w_rfRd;
         if (loadb) r_b <= w_rfRd;
         if (loadc) r_c <= w_result;
         if (loads) begin
            r_z <= w_z;
            r_n <= w_n;
            r_v <= w_v;
         end
      end
   end

   assign datapath_out = r_c;
   assign z_out        = r_z;
   assign n_out        = r_n;
   assign v_out        = r_v;

endmodule

// File: tb/tb_exec_core.sv
// Scoreboard bench for exec_core: directed vectors push expected C/flags,
// a negedge monitor pops and compares after every loadc/loads edge.
module tb_exec_core;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in;
   logic [2:0]  writenum;
   logic        write;
   logic [2:0]  readnum;
   logic        loada;
   logic        loadb;
   logic [1:0]  shift;
   logic        asel;
   logic        bsel;
   logic [15:0] sximm5;
   logic [1:0]  aluop;
   logic        loadc;
   logic        loads;
   logic [15:0] datapath_out;
   logic        z_out;
   logic        n_out;
   logic        v_out;

   typedef struct {
      int          id;
      logic [15:0] c;
      logic        z;
      logic        n;
      logic        v;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   opId  = 0;
   logic pendingCheck = 1'b0;

   exec_core dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .writenum     (writenum),
      .write        (write),
      .readnum      (readnum),
      .loada        (loada),
      .loadb        (loadb),
      .shift        (shift),
      .asel         (asel),
      .bsel         (bsel),
      .sximm5       (sximm5),
      .aluop        (aluop),
      .loadc        (loadc),
      .loads        (loads),
      .datapath_out (datapath_out),
      .z_out        (z_out),
      .n_out        (n_out),
      .v_out        (v_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drives one cycle of strobes at the negedge; pushes the expected result if it updates C or flags
   task automatic applyStimulus(input logic wr, input logic [2:0] wn, input logic [15:0] din,
                                input logic [2:0] rn, input logic la, input logic lb,
                                input logic [1:0] sh, input logic as, input logic bs,
                                input logic [15:0] imm, input logic [1:0] op,
                                input logic lc, input logic ls,
                                input logic [15:0] eC, input logic eZ, input logic eN, input logic eV);
      exp_t e;
      @(negedge clk);
      write = wr; writenum = wn; data_in = din; readnum = rn;
      loada = la; loadb = lb; shift = sh; asel = as; bsel = bs;
      sximm5 = imm; aluop = op; loadc = lc; loads = ls;
      if (lc || ls) begin
         opId++;
         e.id = opId; e.c = eC; e.z = eZ; e.n = eN; e.v = eV;
         expQ.push_back(e);
      end
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic writeReg(input logic [2:0] idx, input logic [15:0] val);
      applyStimulus(1, idx, val, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic loadA(input logic [2:0] idx);
      applyStimulus(0, 0, 0, idx, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic loadB(input logic [2:0] idx);
      applyStimulus(0, 0, 0, idx, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic exec(input logic as, input logic bs, input logic [1:0] sh, input logic [1:0] op,
                       input logic [15:0] imm, input logic lc, input logic ls,
                       input logic [15:0] eC, input logic eZ, input logic eN, input logic eV);
      applyStimulus(0, 0, 0, 0, 0, 0, sh, as, bs, imm, op, lc, ls, eC, eZ, eN, eV);
   endtask

   // Outputs change only at an edge that carried loadc/loads out of reset
   always @(posedge clk) pendingCheck <= rst_n && (loadc || loads);

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pendingCheck) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_output actual=%h expected=none", datapath_out);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("op%0d_c", e.id), datapath_out, e.c);
               checkOutput($sformatf("op%0d_z", e.id), {15'd0, z_out}, {15'd0, e.z});
               checkOutput($sformatf("op%0d_n", e.id), {15'd0, n_out}, {15'd0, e.n});
               checkOutput($sformatf("op%0d_v", e.id), {15'd0, v_out}, {15'd0, e.v});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] fwdExp;
`ifdef EXEC_CORE_WRITE_FORWARD_EN
      fwdExp = 16'h1234;
`else
      fwdExp = 16'h7FFF;
`endif
      rst_n = 1'b0;
      write = 0; writenum = 0; data_in = 0; readnum = 0; loada = 0; loadb = 0;
      shift = 0; asel = 0; bsel = 0; sximm5 = 0; aluop = 0; loadc = 0; loads = 0;
      #2;
      checkOutput("reset_c", datapath_out, 16'h0000);
      checkOutput("reset_flags", {13'd0, z_out, n_out, v_out}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      writeReg(0, 16'd7);
      writeReg(1, 16'd2);
      loadA(0);
      loadB(1);
      exec(0, 0, 2'b00, 2'b00, 0, 1, 1, 16'd9, 0, 0, 0);

      writeReg(2, 16'h8001);
      loadB(2);
      exec(1, 0, 2'b01, 2'b00, 0, 1, 1, 16'h0002, 0, 0, 0);
      exec(1, 0, 2'b10, 2'b00, 0, 1, 1, 16'h4000, 0, 0, 0);
      exec(1, 0, 2'b11, 2'b00, 0, 1, 1, 16'hC000, 0, 1, 0);

      writeReg(3, 16'h7FFF);
      writeReg(4, 16'h0001);
      loadA(3);
      loadB(4);
      exec(0, 0, 2'b00, 2'b00, 0, 1, 1, 16'h8000, 0, 1, 1);

      writeReg(5, 16'd5);
      applyStimulus(0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exec(0, 0, 2'b00, 2'b01, 0, 1, 1, 16'h0000, 1, 0, 0);

      writeReg(6, 16'h8000);
      loadA(6);
      loadB(4);
      exec(0, 0, 2'b00, 2'b01, 0, 1, 1, 16'h7FFF, 0, 0, 1);

      writeReg(7, 16'hF0F0);
      writeReg(0, 16'h0FF0);
      loadA(7);
      loadB(0);
      exec(0, 0, 2'b00, 2'b10, 0, 1, 1, 16'h00F0, 0, 0, 0);
      exec(0, 0, 2'b00, 2'b11, 0, 1, 1, 16'hF00F, 0, 1, 0);
      exec(0, 1, 2'b00, 2'b00, 16'hFFFF, 1, 1, 16'hF0EF, 0, 1, 0);

      applyStimulus(1, 3, 16'h1234, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exec(0, 1, 2'b00, 2'b00, 16'h0000, 1, 1, fwdExp, 0, 0, 0);
      loadA(3);
      exec(0, 1, 2'b00, 2'b00, 16'h0000, 1, 1, 16'h1234, 0, 0, 0);
      exec(1, 1, 2'b00, 2'b11, 16'hFFFF, 0, 1, 16'h1234, 1, 0, 0);
      idle();

      @(posedge clk);
      #2;
      write = 1; writenum = 0; data_in = 16'hFFFF; readnum = 0;
      loada = 1; loadb = 1; loadc = 1; loads = 1; aluop = 2'b11;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset_c", datapath_out, 16'h0000);
      checkOutput("midreset_flags", {13'd0, z_out, n_out, v_out}, 16'h0000);
      @(negedge clk);
      write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0; aluop = 0;
      @(negedge clk);
      rst_n = 1'b1;

      exec(0, 0, 2'b00, 2'b00, 0, 1, 1, 16'h0000, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 3'(i), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         exec(0, 0, 2'b00, 2'b10, 0, 1, 1, 16'h0000, 1, 0, 0);
      end
      idle();
      idle();

      for (int k = 0; k < 20 && expQ.size() != 0; k++) @(negedge clk);
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_core.md
Name: exec_core

Overview:
- Execution core of the simple RISC machine: 8x16 register file, A/B operand registers, barrel-free 1-bit shifter on B, 4-op ALU, C result register and Z/N/V status register.
- Sits between the controller FSM (drives all select/load strobes) and the write-back mux. The write-back mux is outside the block and feeds data_in.
- Controller sequences a typical op as: read into A, read into B, execute into C/status, write back.

Parameters:
- WIDTH, 16, data path and register width.
- NREGS, 8, register count (index width is log2(NREGS) = 3).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  16  write-back value for the register file.
- writenum  input  3  destination register index.
- write  input  1  register file write enable.
- readnum  input  3  source register index.
- loada  input  1  capture the register file read value into A.
- loadb  input  1  capture the register file read value into B.
- shift  input  2  shifter operation applied to B.
- asel  input  1  selects ALU A input: 1 = zero, 0 = A register.
- bsel  input  1  selects ALU B input: 1 = sximm5, 0 = shifter output.
- sximm5  input  16  sign-extended immediate.
- aluop  input  2  ALU operation.
- loadc  input  1  capture the ALU result into C.
- loads  input  1  capture the status flags.
- datapath_out  output  16  C register.
- z_out  output  1  registered zero flag.
- n_out  output  1  registered negative flag.
- v_out  output  1  registered overflow flag.

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, all registers R0-R7, A, B, C, z_out, n_out and v_out are forced to 0, overriding every load strobe.
- Register file write: at a rising clk edge with write=1, R[writenum] <= data_in.
- Register file read: combinational; rf_rd = R[readnum].
- Operand capture: at the edge, A <= rf_rd if loada=1; B <= rf_rd if loadb=1. Otherwise A and B hold.
- Simultaneous write and read of the same index in one cycle: A/B capture the old value (read-before-write), unless the optional feature is enabled.
- Shifter (combinational, on B):
  - 00: B unchanged.
  - 01: B<<1, LSB filled with 0.
  - 10: B>>1, MSB filled with 0.
  - 11: B>>1, MSB keeps B[15] (arithmetic shift).
- ALU (combinational), results modulo 2^16:
  - 00: Ain+Bin.
  - 01: Ain-Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
- Flags (combinational):
  - Z = (result==0).
  - N = result[15].
  - V for add = (Ain[15]==Bin[15]) && (result[15]!=Ain[15]).
  - V for sub = (Ain[15]!=Bin[15]) && (result[15]!=Ain[15]).
  - V = 0 for AND and NOT.
- Result capture: at the edge, C <= result if loadc=1; z_out/n_out/v_out <= Z/N/V if loads=1. Otherwise they hold.
- Latency: register read to C takes 2 edges (load A/B, then loadc). datapath_out and the flags are valid after the loadc/loads edge.
- All strobes are independent. Any combination in one cycle is legal, and each register uses the values present before that edge.

Optional Feature:
- Macro: EXEC_CORE_WRITE_FORWARD_EN.
- Defined: when write=1 and writenum==readnum, rf_rd = data_in in the same cycle, so A/B capture the new value.
- Undefined: read-before-write as specified above.

Decomposition:
- Shared package exec_core_pkg holds:
  - Constants: WIDTH, NREGS.
  - Enum alu_op_e: ADD, SUB, AND, NOT.
  - Enum shift_op_e: NONE, SHL, SHR, ASR.
- One sub-module is natural: exec_core_regfile (8x16 storage, async-reset write port, combinational read).
- Shifter and ALU are small combinational logic inline in exec_core.

Test Plan:
- Reset: pulse rst_n low mid-cycle with load strobes active -> R0-R7, A, B, C all read 0 and z_out=n_out=v_out=0 immediately, without waiting for a clock edge.
- Write/read and add: write R0=7 and R1=2; load A from R0 and B from R1; shift=00, aluop=00, loadc=1 -> datapath_out=9, Z=0, N=0, V=0.
- Shifter on B=0x8001: shift=01 -> 0x0002; shift=10 -> 0x4000; shift=11 -> 0xC000 (checked with asel=1, aluop=00, loadc=1).
- Signed overflow, add: A=0x7FFF, B=0x0001 -> result 0x8000, N=1, V=1.
- Zero and subtract overflow:
  - A=5, B=5, aluop=01, loads=1 -> z_out=1.
  - A=0x8000, B=1, aluop=01 -> result 0x7FFF, V=1.
- Logic ops and same-cycle read/write:
  - A=0xF0F0, B=0x0FF0: aluop=10 -> 0x00F0; aluop=11 -> 0xF00F.
  - Write R3=0x1234 while readnum=3, loada=1 -> A keeps the old R3 without the macro, and is 0x1234 with EXEC_CORE_WRITE_FORWARD_EN defined.
